exu_lsu_pipe: RTL and testbench

EXU_LSU_PIPE -- requirements
Module: exu_lsu_pipe

---
 rtl/exu_lsu_pipe_pkg.sv | 39 +++
 rtl/exu_lsu_align.sv | 44 ++++
 rtl/exu_lsu_pipe.sv | 196 +++++++++++++++++++
 tb/tb_exu_lsu_pipe.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_lsu_pipe_pkg.sv
// Shared opcode/funct3 constants, FSM encoding and helpers for the LSU execution pipe.
package exu_lsu_pipe_pkg;

  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcStore = 7'b0100011;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Ld  = 3'b011;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Lwu = 3'b110;

  localparam logic [2:0] F3Sb = 3'b000;
  localparam logic [2:0] F3Sh = 3'b001;
  localparam logic [2:0] F3Sw = 3'b010;
  localparam logic [2:0] F3Sd = 3'b011;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDrain
  } lsu_state_e;

  // size is log2 of the access width in bytes (funct3[1:0] for every load/store)
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
    logic mis;
    unique case (size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = addr_lo[0];
      2'd2:    mis = |addr_lo[1:0];
      default: mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/exu_lsu_align.sv
// Byte-lane steering: store data/strobe placement and load field extract with extension.
module exu_lsu_align
  import exu_lsu_pipe_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  addr_lo,
  input  logic [63:0] src2,
  input  logic [63:0] rdata,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic [63:0] load_data
);

  logic [5:0]  bit_shift;
  logic [63:0] rdata_shifted;

  assign bit_shift     = {addr_lo, 3'b000};
  assign rdata_shifted = rdata >> bit_shift;
  assign wdata         = src2 << bit_shift;

  always_comb begin
    unique case (funct3[1:0])
      2'd0:    wstrb = 8'h01 << addr_lo;
      2'd1:    wstrb = 8'h03 << addr_lo;
      2'd2:    wstrb = 8'h0f << addr_lo;
      default: wstrb = 8'hff;
    endcase
  end

  always_comb begin
    load_data = rdata_shifted;
    unique case (funct3)
      F3Lb:    load_data = {{56{rdata_shifted[7]}}, rdata_shifted[7:0]};
      F3Lh:    load_data = {{48{rdata_shifted[15]}}, rdata_shifted[15:0]};
      F3Lw:    load_data = {{32{rdata_shifted[31]}}, rdata_shifted[31:0]};
      F3Ld:    load_data = rdata_shifted;
      F3Lbu:   load_data = {56'd0, rdata_shifted[7:0]};
      F3Lhu:   load_data = {48'd0, rdata_shifted[15:0]};
      F3Lwu:   load_data = {32'd0, rdata_shifted[31:0]};
      default: load_data = rdata_shifted;
    endcase
  end

endmodule

// File: rtl/exu_lsu_pipe.sv
// Single-outstanding load/store execution pipe: address generation, memory request,
// response writeback and completion, with global-flush handling.
module exu_lsu_pipe
  import exu_lsu_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_clk,
  input  logic        rtu_global_flush,
  input  logic        idu_exu_lsu_issue_vld,
  input  logic [4:0]  idu_exu_lsu_iid,
  input  logic [6:0]  idu_exu_lsu_opcode,
  input  logic [2:0]  idu_exu_lsu_funct3,
  input  logic        idu_exu_lsu_pdst_vld,
  input  logic [5:0]  idu_exu_lsu_pdst,
  input  logic [63:0] idu_exu_lsu_src1,
  input  logic [63:0] idu_exu_lsu_src2,
  input  logic [63:0] idu_exu_lsu_imm,
  output logic        exu_idu_lsu_ready,
  output logic        lsu_mem_req_vld,
  input  logic        lsu_mem_req_ready,
  output logic [63:0] lsu_mem_addr,
  output logic        lsu_mem_wen,
  output logic [63:0] lsu_mem_wdata,
  output logic [7:0]  lsu_mem_wstrb,
  input  logic        mem_lsu_resp_vld,
  input  logic [63:0] mem_lsu_rdata,
  output logic        exu_idu_is_lsu_result_vld,
  output logic [5:0]  exu_idu_is_lsu_result_preg,
  output logic [63:0] exu_lsu_result_data,
  output logic        exu_rtu_lsu_cmplt_vld,
  output logic [4:0]  exu_rtu_lsu_cmplt_iid,
  output logic        exu_rtu_lsu_misalign
);

  lsu_state_e state_q, state_d;

  logic [4:0]  iid_q;
  logic [5:0]  pdst_q;
  logic        pdst_vld_q;
  logic [2:0]  funct3_q;
  logic        load_q;
  logic [63:0] addr_q;
  logic [63:0] src2_q;

  logic        cmplt_vld_q, cmplt_vld_d;
  logic [4:0]  cmplt_iid_q, cmplt_iid_d;
  logic        misalign_q, misalign_d;
  logic        result_vld_q, result_vld_d;
  logic [5:0]  result_preg_q, result_preg_d;
  logic [63:0] result_data_q, result_data_d;

  logic        accept;
  logic [63:0] issue_addr;
  logic        issue_load;
  logic        issue_store;
  logic        issue_mem;
  logic        issue_mis;

  logic [63:0] align_wdata;
  logic [7:0]  align_wstrb;
  logic [63:0] align_load_data;

  assign exu_idu_lsu_ready = (state_q == StIdle);
  assign accept = idu_exu_lsu_issue_vld & exu_idu_lsu_ready & ~rtu_global_flush;
  assign issue_addr = idu_exu_lsu_src1 + idu_exu_lsu_imm;

  assign issue_load = (idu_exu_lsu_opcode == OpcLoad) &&
                      (idu_exu_lsu_funct3 inside {F3Lb, F3Lh, F3Lw, F3Ld, F3Lbu, F3Lhu, F3Lwu});
  assign issue_store = (idu_exu_lsu_opcode == OpcStore) &&
                       (idu_exu_lsu_funct3 inside {F3Sb, F3Sh, F3Sw, F3Sd});
  assign issue_mem = issue_load | issue_store;
  assign issue_mis = issue_mem & lsu_misaligned(idu_exu_lsu_funct3[1:0], issue_addr[2:0]);

  exu_lsu_align u_align (
    .funct3    (funct3_q),
    .addr_lo   (addr_q[2:0]),
    .src2      (src2_q),
    .rdata     (mem_lsu_rdata),
    .wdata     (align_wdata),
    .wstrb     (align_wstrb),
    .load_data (align_load_data)
  );

  always_comb begin
    state_d       = state_q;
    cmplt_vld_d   = 1'b0;
    cmplt_iid_d   = '0;
    misalign_d    = 1'b0;
    result_vld_d  = 1'b0;
    result_preg_d = '0;
    result_data_d = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (issue_mem && !issue_mis) begin
            state_d = StReq;
          end else begin
            // Misaligned or non-memory ops retire immediately without touching memory
            cmplt_vld_d = 1'b1;
            cmplt_iid_d = idu_exu_lsu_iid;
            misalign_d  = issue_mis;
          end
        end
      end
      StReq: begin
        if (lsu_mem_req_ready) begin
          if (load_q) begin
            state_d = rtu_global_flush ? StDrain : StWait;
          end else begin
            state_d = StIdle;
            if (!rtu_global_flush) begin
              cmplt_vld_d = 1'b1;
              cmplt_iid_d = iid_q;
            end
          end
        end else if (rtu_global_flush) begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (rtu_global_flush) begin
          // A response arriving with the flush is consumed here, so nothing is left to drain
          state_d = mem_lsu_resp_vld ? StIdle : StDrain;
        end else if (mem_lsu_resp_vld) begin
          state_d       = StIdle;
          cmplt_vld_d   = 1'b1;
          cmplt_iid_d   = iid_q;
          result_vld_d  = pdst_vld_q;
          result_preg_d = pdst_vld_q ? pdst_q : '0;
          result_data_d = align_load_data;
        end
      end
      StDrain: begin
        if (mem_lsu_resp_vld) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      state_q       <= StIdle;
      cmplt_vld_q   <= 1'b0;
      cmplt_iid_q   <= '0;
      misalign_q    <= 1'b0;
      result_vld_q  <= 1'b0;
      result_preg_q <= '0;
      result_data_q <= '0;
    end else begin
      state_q       <= state_d;
      cmplt_vld_q   <= cmplt_vld_d;
      cmplt_iid_q   <= cmplt_iid_d;
      misalign_q    <= misalign_d;
      result_vld_q  <= result_vld_d;
      result_preg_q <= result_preg_d;
      result_data_q <= result_data_d;
    end
  end

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      iid_q      <= '0;
      pdst_q     <= '0;
      pdst_vld_q <= 1'b0;
      funct3_q   <= '0;
      load_q     <= 1'b0;
      addr_q     <= '0;
      src2_q     <= '0;
    end else if (accept) begin
      iid_q      <= idu_exu_lsu_iid;
      pdst_q     <= idu_exu_lsu_pdst;
      pdst_vld_q <= idu_exu_lsu_pdst_vld;
      funct3_q   <= idu_exu_lsu_funct3;
      load_q     <= issue_load;
      addr_q     <= issue_addr;
      src2_q     <= idu_exu_lsu_src2;
    end
  end

  // Request fields only come from captured state, so they hold steady while stalled
  assign lsu_mem_req_vld = (state_q == StReq);
  assign lsu_mem_addr    = lsu_mem_req_vld ? {addr_q[63:3], 3'b000} : '0;
  assign lsu_mem_wen     = lsu_mem_req_vld & ~load_q;
  assign lsu_mem_wdata   = lsu_mem_wen ? align_wdata : '0;
  assign lsu_mem_wstrb   = lsu_mem_wen ? align_wstrb : '0;

  assign exu_idu_is_lsu_result_vld  = result_vld_q;
  assign exu_idu_is_lsu_result_preg = result_preg_q;
  assign exu_lsu_result_data        = result_data_q;
  assign exu_rtu_lsu_cmplt_vld      = cmplt_vld_q;
  assign exu_rtu_lsu_cmplt_iid      = cmplt_iid_q;
  assign exu_rtu_lsu_misalign       = misalign_q;

endmodule

// File: tb/tb_exu_lsu_pipe.sv
// Self-checking bench for exu_lsu_pipe: directed vector table, flush/stall sequences and
// randomized ops against a transaction-level reference model.
module tb_exu_lsu_pipe;

  logic        clk;
  logic        rst_clk;
  logic        rtu_global_flush;
  logic        idu_exu_lsu_issue_vld;
  logic [4:0]  idu_exu_lsu_iid;
  logic [6:0]  idu_exu_lsu_opcode;
  logic [2:0]  idu_exu_lsu_funct3;
  logic        idu_exu_lsu_pdst_vld;
  logic [5:0]  idu_exu_lsu_pdst;
  logic [63:0] idu_exu_lsu_src1;
  logic [63:0] idu_exu_lsu_src2;
  logic [63:0] idu_exu_lsu_imm;
  logic        exu_idu_lsu_ready;
  logic        lsu_mem_req_vld;
  logic        lsu_mem_req_ready;
  logic [63:0] lsu_mem_addr;
  logic        lsu_mem_wen;
  logic [63:0] lsu_mem_wdata;
  logic [7:0]  lsu_mem_wstrb;
  logic        mem_lsu_resp_vld;
  logic [63:0] mem_lsu_rdata;
  logic        exu_idu_is_lsu_result_vld;
  logic [5:0]  exu_idu_is_lsu_result_preg;
  logic [63:0] exu_lsu_result_data;
  logic        exu_rtu_lsu_cmplt_vld;
  logic [4:0]  exu_rtu_lsu_cmplt_iid;
  logic        exu_rtu_lsu_misalign;

  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;

  int n_checks = 0;
  int n_fails  = 0;

  exu_lsu_pipe dut (
    .clk                        (clk),
    .rst_clk                    (rst_clk),
    .rtu_global_flush           (rtu_global_flush),
    .idu_exu_lsu_issue_vld      (idu_exu_lsu_issue_vld),
    .idu_exu_lsu_iid            (idu_exu_lsu_iid),
    .idu_exu_lsu_opcode         (idu_exu_lsu_opcode),
    .idu_exu_lsu_funct3         (idu_exu_lsu_funct3),
    .idu_exu_lsu_pdst_vld       (idu_exu_lsu_pdst_vld),
    .idu_exu_lsu_pdst           (idu_exu_lsu_pdst),
    .idu_exu_lsu_src1           (idu_exu_lsu_src1),
    .idu_exu_lsu_src2           (idu_exu_lsu_src2),
    .idu_exu_lsu_imm            (idu_exu_lsu_imm),
    .exu_idu_lsu_ready          (exu_idu_lsu_ready),
    .lsu_mem_req_vld            (lsu_mem_req_vld),
    .lsu_mem_req_ready          (lsu_mem_req_ready),
    .lsu_mem_addr               (lsu_mem_addr),
    .lsu_mem_wen                (lsu_mem_wen),
    .lsu_mem_wdata              (lsu_mem_wdata),
    .lsu_mem_wstrb              (lsu_mem_wstrb),
    .mem_lsu_resp_vld           (mem_lsu_resp_vld),
    .mem_lsu_rdata              (mem_lsu_rdata),
    .exu_idu_is_lsu_result_vld  (exu_idu_is_lsu_result_vld),
    .exu_idu_is_lsu_result_preg (exu_idu_is_lsu_result_preg),
    .exu_lsu_result_data        (exu_lsu_result_data),
    .exu_rtu_lsu_cmplt_vld      (exu_rtu_lsu_cmplt_vld),
    .exu_rtu_lsu_cmplt_iid      (exu_rtu_lsu_cmplt_iid),
    .exu_rtu_lsu_misalign       (exu_rtu_lsu_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [63:0] src1;
    logic [63:0] imm;
    logic [63:0] src2;
    logic [63:0] rdata;
    logic        pv;
    logic [5:0]  pdst;
    logic        e_mis;
    logic        e_req;
    logic [63:0] e_addr;
    logic [7:0]  e_wstrb;
    logic [63:0] e_wdata;
    logic        e_rvld;
    logic [63:0] e_res;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] lane_mask(input logic [7:0] strb);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{strb[i]}};
    return m;
  endfunction

  // Reference load result: pick the naturally sized field at byte offset off, then extend
  function automatic logic [63:0] model_load(input logic [2:0] f3, input int off,
                                             input logic [63:0] rd);
    int          nb;
    logic [63:0] v;
    logic [63:0] m;
    nb = 1 << f3[1:0];
    v  = rd >> (8 * off);
    if (nb == 8) return v;
    m = (64'd1 << (8 * nb)) - 64'd1;
    v = v & m;
    if (!f3[2] && v[8*nb-1]) v = v | ~m;
    return v;
  endfunction

  task automatic drive_issue(input logic [6:0] opc, input logic [2:0] f3, input logic [63:0] s1,
                             input logic [63:0] im, input logic [63:0] s2, input logic [4:0] iid,
                             input logic pv, input logic [5:0] pdst);
    idu_exu_lsu_issue_vld = 1'b1;
    idu_exu_lsu_opcode    = opc;
    idu_exu_lsu_funct3    = f3;
    idu_exu_lsu_src1      = s1;
    idu_exu_lsu_imm       = im;
    idu_exu_lsu_src2      = s2;
    idu_exu_lsu_iid       = iid;
    idu_exu_lsu_pdst_vld  = pv;
    idu_exu_lsu_pdst      = pdst;
  endtask

  // Best-case timing: memory ready immediately, response the cycle after the handshake
  task automatic apply_vec(input vec_t v, input int idx);
    logic [4:0] iid;
    iid = 5'(idx + 1);
    drive_issue(v.opc, v.f3, v.src1, v.imm, v.src2, iid, v.pv, v.pdst);
    chk($sformatf("v%0d_ready", idx), 64'(exu_idu_lsu_ready), 64'd1);
    step();
    idu_exu_lsu_issue_vld = 1'b0;
    chk($sformatf("v%0d_req_vld", idx), 64'(lsu_mem_req_vld), 64'(v.e_req));
    if (!v.e_req) begin
      chk($sformatf("v%0d_cmplt", idx), 64'(exu_rtu_lsu_cmplt_vld), 64'd1);
      chk($sformatf("v%0d_mis", idx), 64'(exu_rtu_lsu_misalign), 64'(v.e_mis));
      chk($sformatf("v%0d_iid", idx), 64'(exu_rtu_lsu_cmplt_iid), 64'(iid));
      chk($sformatf("v%0d_rvld", idx), 64'(exu_idu_is_lsu_result_vld), 64'd0);
      step();
      return;
    end
    chk($sformatf("v%0d_addr", idx), lsu_mem_addr, v.e_addr);
    chk($sformatf("v%0d_wstrb", idx), 64'(lsu_mem_wstrb), 64'(v.e_wstrb));
    chk($sformatf("v%0d_wen", idx), 64'(lsu_mem_wen), 64'(v.opc == OPC_ST));
    if (v.e_wstrb != 8'h00)
      chk($sformatf("v%0d_wdata", idx), lsu_mem_wdata & lane_mask(v.e_wstrb), v.e_wdata);
    lsu_mem_req_ready = 1'b1;
    step();
    lsu_mem_req_ready = 1'b0;
    if (v.opc == OPC_ST) begin
      chk($sformatf("v%0d_st_cmplt", idx), 64'(exu_rtu_lsu_cmplt_vld), 64'd1);
      chk($sformatf("v%0d_st_rvld", idx), 64'(exu_idu_is_lsu_result_vld), 64'd0);
      step();
      return;
    end
    chk($sformatf("v%0d_ld_early", idx), 64'(exu_rtu_lsu_cmplt_vld), 64'd0);
    mem_lsu_resp_vld = 1'b1;
    mem_lsu_rdata    = v.rdata;
    step();
    mem_lsu_resp_vld = 1'b0;
    chk($sformatf("v%0d_ld_cmplt", idx), 64'(exu_rtu_lsu_cmplt_vld), 64'd1);
    chk($sformatf("v%0d_ld_iid", idx), 64'(exu_rtu_lsu_cmplt_iid), 64'(iid));
    chk($sformatf("v%0d_rvld", idx), 64'(exu_idu_is_lsu_result_vld), 64'(v.e_rvld));
    chk($sformatf("v%0d_preg", idx), 64'(exu_idu_is_lsu_result_preg),
        v.e_rvld ? 64'(v.pdst) : 64'd0);
    if (v.e_rvld) chk($sformatf("v%0d_data", idx), exu_lsu_result_data, v.e_res);
    step();
  endtask

  task automatic rand_op(input int n);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [63:0] s1, im, s2, rd, addr, e_wdata, e_res;
    logic [4:0]  iid;
    logic [5:0]  pdst;
    logic [7:0]  e_strb;
    logic        pv, is_ld, is_st, mis;
    int          kind, nb, off, dreq, dresp;
    kind = int'($urandom_range(0, 9));
    is_ld = (kind < 6);
    is_st = (kind >= 6) && (kind < 9);
    if (is_ld) begin
      opc = OPC_LD;
      f3  = 3'($urandom_range(0, 6));
    end else if (is_st) begin
      opc = OPC_ST;
      f3  = 3'($urandom_range(0, 3));
    end else begin
      opc = 7'b0010011;
      f3  = 3'($urandom_range(0, 7));
    end
    s1   = {$urandom, $urandom};
    im   = 64'($urandom_range(0, 255));
    s2   = {$urandom, $urandom};
    rd   = {$urandom, $urandom};
    iid  = 5'($urandom);
    pdst = 6'($urandom);
    pv   = 1'($urandom);
    addr = s1 + im;
    nb   = 1 << f3[1:0];
    off  = int'(addr[2:0]);
    mis  = (is_ld || is_st) && ((off % nb) != 0);
    e_strb  = '0;
    e_wdata = '0;
    for (int i = 0; i < 8; i++) begin
      if (i >= off && i < off + nb) begin
        e_strb[i] = 1'b1;
        e_wdata[8*i +: 8] = s2[8*(i-off) +: 8];
      end
    end
    e_res = model_load(f3, off, rd);

    drive_issue(opc, f3, s1, im, s2, iid, pv, pdst);
    chk($sformatf("r%0d_ready", n), 64'(exu_idu_lsu_ready), 64'd1);
    step();
    idu_exu_lsu_issue_vld = 1'b0;
    if (!(is_ld || is_st) || mis) begin
      chk($sformatf("r%0d_noreq", n), 64'(lsu_mem_req_vld), 64'd0);
      chk($sformatf("r%0d_cmplt", n), 64'(exu_rtu_lsu_cmplt_vld), 64'd1);
      chk($sformatf("r%0d_iid", n), 64'(exu_rtu_lsu_cmplt_iid), 64'(iid));
      chk($sformatf("r%0d_mis", n), 64'(exu_rtu_lsu_misalign), 64'(mis));
      chk($sformatf("r%0d_rvld", n), 64'(exu_idu_is_lsu_result_vld), 64'd0);
      step();
      return;
    end
    dreq = int'($urandom_range(0, 3));
    for (int c = 0; c <= dreq; c++) begin
      lsu_mem_req_ready = (c == dreq);
      chk($sformatf("r%0d_req_vld", n), 64'(lsu_mem_req_vld), 64'd1);
      chk($sformatf("r%0d_addr", n), lsu_mem_addr, {addr[63:3], 3'b000});
      chk($sformatf("r%0d_wen", n), 64'(lsu_mem_wen), 64'(is_st));
      chk($sformatf("r%0d_wstrb", n), 64'(lsu_mem_wstrb), is_st ? 64'(e_strb) : 64'd0);
      if (is_st) chk($sformatf("r%0d_wdata", n), lsu_mem_wdata & lane_mask(e_strb), e_wdata);
      chk($sformatf("r%0d_stall_cmplt", n), 64'(exu_rtu_lsu_cmplt_vld), 64'd0);
      step();
    end
    lsu_mem_req_ready = 1'b0;
    if (is_st) begin
      chk($sformatf("r%0d_st_cmplt", n), 64'(exu_rtu_lsu_cmplt_vld), 64'd1);
      chk($sformatf("r%0d_st_iid", n), 64'(exu_rtu_lsu_cmplt_iid), 64'(iid));
      chk($sformatf("r%0d_st_rvld", n), 64'(exu_idu_is_lsu_result_vld), 64'd0);
      step();
      return;
    end
    dresp = int'($urandom_range(0, 3));
    for (int c = 0; c <= dresp; c++) begin
      mem_lsu_resp_vld = (c == dresp);
      mem_lsu_rdata    = (c == dresp) ? rd : {$urandom, $urandom};
      chk($sformatf("r%0d_wait_ready", n), 64'(exu_idu_lsu_ready), 64'd0);
      chk($sformatf("r%0d_wait_cmplt", n), 64'(exu_rtu_lsu_cmplt_vld), 64'd0);
      step();
    end
    mem_lsu_resp_vld = 1'b0;
    chk($sformatf("r%0d_ld_cmplt", n), 64'(exu_rtu_lsu_cmplt_vld), 64'd1);
    chk($sformatf("r%0d_ld_iid", n), 64'(exu_rtu_lsu_cmplt_iid), 64'(iid));
    chk($sformatf("r%0d_ld_rvld", n), 64'(exu_idu_is_lsu_result_vld), 64'(pv));
    chk($sformatf("r%0d_ld_preg", n), 64'(exu_idu_is_lsu_result_preg), pv ? 64'(pdst) : 64'd0);
    if (pv) chk($sformatf("r%0d_ld_data", n), exu_lsu_result_data, e_res);
    step();
  endtask

  initial begin
    int pulses;
    int rv_seen;

    vecs[0]  = '{OPC_LD, 3'd3, 64'h1000, 64'd8, 64'd0, 64'h1122334455667788, 1'b1, 6'd5,
                 1'b0, 1'b1, 64'h1008, 8'h00, 64'd0, 1'b1, 64'h1122334455667788};
    vecs[1]  = '{OPC_LD, 3'd0, 64'h1000, 64'd3, 64'd0, 64'h0000000080000000, 1'b1, 6'd7,
                 1'b0, 1'b1, 64'h1000, 8'h00, 64'd0, 1'b1, 64'hFFFFFFFFFFFFFF80};
    vecs[2]  = '{OPC_LD, 3'd4, 64'h1000, 64'd3, 64'd0, 64'h0000000080000000, 1'b1, 6'd8,
                 1'b0, 1'b1, 64'h1000, 8'h00, 64'd0, 1'b1, 64'h0000000000000080};
    vecs[3]  = '{OPC_LD, 3'd2, 64'h1000, 64'd2, 64'd0, 64'd0, 1'b1, 6'd9,
                 1'b1, 1'b0, 64'd0, 8'h00, 64'd0, 1'b0, 64'd0};
    vecs[4]  = '{OPC_ST, 3'd3, 64'h3000, 64'h10, 64'h0123456789ABCDEF, 64'd0, 1'b1, 6'd10,
                 1'b0, 1'b1, 64'h3010, 8'hFF, 64'h0123456789ABCDEF, 1'b0, 64'd0};
    vecs[5]  = '{OPC_ST, 3'd2, 64'h3000, 64'd4, 64'hFFFF0000DEADBEEF, 64'd0, 1'b0, 6'd0,
                 1'b0, 1'b1, 64'h3000, 8'hF0, 64'hDEADBEEF00000000, 1'b0, 64'd0};
    vecs[6]  = '{OPC_LD, 3'd1, 64'h4000, 64'd6, 64'd0, 64'h8001000000000000, 1'b1, 6'd63,
                 1'b0, 1'b1, 64'h4000, 8'h00, 64'd0, 1'b1, 64'hFFFFFFFFFFFF8001};
    vecs[7]  = '{OPC_LD, 3'd6, 64'h4000, 64'd4, 64'd0, 64'hF000000112345678, 1'b0, 6'd12,
                 1'b0, 1'b1, 64'h4000, 8'h00, 64'd0, 1'b0, 64'd0};
    vecs[8]  = '{7'b0110011, 3'd0, 64'h10, 64'd0, 64'd0, 64'd0, 1'b1, 6'd3,
                 1'b0, 1'b0, 64'd0, 8'h00, 64'd0, 1'b0, 64'd0};
    vecs[9]  = '{OPC_ST, 3'd0, 64'h5000, 64'd7, 64'h12AA, 64'd0, 1'b0, 6'd0,
                 1'b0, 1'b1, 64'h5000, 8'h80, 64'hAA00000000000000, 1'b0, 64'd0};
    vecs[10] = '{OPC_ST, 3'd1, 64'h5001, 64'd0, 64'h1234, 64'd0, 1'b0, 6'd0,
                 1'b1, 1'b0, 64'd0, 8'h00, 64'd0, 1'b0, 64'd0};
    vecs[11] = '{OPC_LD, 3'd5, 64'h6000, 64'd2, 64'd0, 64'h00000000BEEF0000, 1'b1, 6'd33,
                 1'b0, 1'b1, 64'h6000, 8'h00, 64'd0, 1'b1, 64'h000000000000BEEF};

    rst_clk               = 1'b0;
    rtu_global_flush      = 1'b0;
    idu_exu_lsu_issue_vld = 1'b0;
    idu_exu_lsu_iid       = '0;
    idu_exu_lsu_opcode    = '0;
    idu_exu_lsu_funct3    = '0;
    idu_exu_lsu_pdst_vld  = 1'b0;
    idu_exu_lsu_pdst      = '0;
    idu_exu_lsu_src1      = '0;
    idu_exu_lsu_src2      = '0;
    idu_exu_lsu_imm       = '0;
    lsu_mem_req_ready     = 1'b0;
    mem_lsu_resp_vld      = 1'b0;
    mem_lsu_rdata         = '0;

    step();
    step();
    chk("rst_req_vld", 64'(lsu_mem_req_vld), 64'd0);
    chk("rst_addr", lsu_mem_addr, 64'd0);
    chk("rst_wstrb", 64'(lsu_mem_wstrb), 64'd0);
    chk("rst_cmplt", 64'(exu_rtu_lsu_cmplt_vld), 64'd0);
    chk("rst_rvld", 64'(exu_idu_is_lsu_result_vld), 64'd0);
    chk("rst_data", exu_lsu_result_data, 64'd0);
    rst_clk = 1'b1;
    step();
    chk("rst_ready", 64'(exu_idu_lsu_ready), 64'd1);

    for (int i = 0; i < 12; i++) apply_vec(vecs[i], i);

    // SH with req_ready held low for three cycles
    drive_issue(OPC_ST, 3'd1, 64'h2000, 64'd6, 64'h000000000000ABCD, 5'd20, 1'b1, 6'd4);
    step();
    idu_exu_lsu_issue_vld = 1'b0;
    for (int c = 0; c < 4; c++) begin
      lsu_mem_req_ready = (c == 3);
      chk("sh_req_vld", 64'(lsu_mem_req_vld), 64'd1);
      chk("sh_addr", lsu_mem_addr, 64'h2000);
      chk("sh_wstrb", 64'(lsu_mem_wstrb), 64'hC0);
      chk("sh_wdata_hi", 64'(lsu_mem_wdata[63:48]), 64'hABCD);
      chk("sh_wen", 64'(lsu_mem_wen), 64'd1);
      step();
    end
    lsu_mem_req_ready = 1'b0;
    pulses  = 0;
    rv_seen = 0;
    for (int c = 0; c < 4; c++) begin
      pulses  += int'(exu_rtu_lsu_cmplt_vld);
      rv_seen += int'(exu_idu_is_lsu_result_vld);
      step();
    end
    chk("sh_cmplt_pulses", 64'(pulses), 64'd1);
    chk("sh_no_result", 64'(rv_seen), 64'd0);

    // Flush while a load is in WAIT, stale response two cycles later, then a fresh load
    drive_issue(OPC_LD, 3'd3, 64'h7000, 64'd0, 64'd0, 5'd3, 1'b1, 6'd9);
    step();
    idu_exu_lsu_issue_vld = 1'b0;
    chk("fw_req", 64'(lsu_mem_req_vld), 64'd1);
    lsu_mem_req_ready = 1'b1;
    step();
    lsu_mem_req_ready = 1'b0;
    rtu_global_flush  = 1'b1;
    chk("fw_wait_ready", 64'(exu_idu_lsu_ready), 64'd0);
    step();
    rtu_global_flush = 1'b0;
    chk("fw_drain_ready", 64'(exu_idu_lsu_ready), 64'd0);
    chk("fw_drain_cmplt", 64'(exu_rtu_lsu_cmplt_vld), 64'd0);
    step();
    chk("fw_drain_ready2", 64'(exu_idu_lsu_ready), 64'd0);
    mem_lsu_resp_vld = 1'b1;
    mem_lsu_rdata    = 64'hDEAD;
    step();
    mem_lsu_resp_vld = 1'b0;
    chk("fw_idle_ready", 64'(exu_idu_lsu_ready), 64'd1);
    chk("fw_stale_cmplt", 64'(exu_rtu_lsu_cmplt_vld), 64'd0);
    chk("fw_stale_rvld", 64'(exu_idu_is_lsu_result_vld), 64'd0);
    drive_issue(OPC_LD, 3'd3, 64'h7008, 64'd0, 64'd0, 5'd4, 1'b1, 6'd10);
    step();
    idu_exu_lsu_issue_vld = 1'b0;
    chk("fw2_addr", lsu_mem_addr, 64'h7008);
    lsu_mem_req_ready = 1'b1;
    step();
    lsu_mem_req_ready = 1'b0;
    mem_lsu_resp_vld  = 1'b1;
    mem_lsu_rdata     = 64'h5555666677778888;
    step();
    mem_lsu_resp_vld = 1'b0;
    chk("fw2_cmplt", 64'(exu_rtu_lsu_cmplt_vld), 64'd1);
    chk("fw2_iid", 64'(exu_rtu_lsu_cmplt_iid), 64'd4);
    chk("fw2_preg", 64'(exu_idu_is_lsu_result_preg), 64'd10);
    chk("fw2_data", exu_lsu_result_data, 64'h5555666677778888);
    step();

    // Flush while request is stalled, then stray responses in IDLE
    drive_issue(OPC_LD, 3'd3, 64'h8000, 64'd0, 64'd0, 5'd5, 1'b1, 6'd11);
    step();
    idu_exu_lsu_issue_vld = 1'b0;
    chk("fr_req", 64'(lsu_mem_req_vld), 64'd1);
    rtu_global_flush = 1'b1;
    step();
    rtu_global_flush = 1'b0;
    chk("fr_req_drop", 64'(lsu_mem_req_vld), 64'd0);
    chk("fr_ready", 64'(exu_idu_lsu_ready), 64'd1);
    chk("fr_cmplt", 64'(exu_rtu_lsu_cmplt_vld), 64'd0);
    mem_lsu_resp_vld = 1'b1;
    mem_lsu_rdata    = 64'h1234;
    step();
    step();
    mem_lsu_resp_vld = 1'b0;
    chk("idle_resp_rvld", 64'(exu_idu_is_lsu_result_vld), 64'd0);
    chk("idle_resp_cmplt", 64'(exu_rtu_lsu_cmplt_vld), 64'd0);

    // Flush in IDLE blocks acceptance
    drive_issue(OPC_LD, 3'd3, 64'h9000, 64'd0, 64'd0, 5'd6, 1'b1, 6'd12);
    rtu_global_flush = 1'b1;
    step();
    rtu_global_flush      = 1'b0;
    idu_exu_lsu_issue_vld = 1'b0;
    chk("fi_no_req", 64'(lsu_mem_req_vld), 64'd0);
    chk("fi_no_cmplt", 64'(exu_rtu_lsu_cmplt_vld), 64'd0);
    chk("fi_ready", 64'(exu_idu_lsu_ready), 64'd1);

    for (int n = 0; n < 60; n++) rand_op(n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

endmodule
